// File: rtl/alu_pkg.sv
// Shared ALU definitions: control code constants and default widths for the
// execute-stage ALU and the blocks that drive it.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 32;
  localparam int ALU_CTRL_WIDTH = 6;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD  = 6'd0;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB  = 6'd1;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR   = 6'd2;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR  = 6'd3;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND  = 6'd4;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL  = 6'd5;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL  = 6'd6;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA  = 6'd7;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT  = 6'd8;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLTU = 6'd9;

endpackage

// File: rtl/rsp_slot.sv
// One-entry valid/ready response register. A load always wins, so a drain and
// a new result in the same cycle keep the slot full with the new data.
module rsp_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  valid_r;
  logic [DATA_WIDTH-1:0] data_r;

  // Slot occupancy and held result; data only changes on a load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_WIDTH{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (valid_r && ready) begin
      valid_r <= 1'b0;
      data_r  <= data_r;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage
// (requester 0) and the address/compare helper (requester 1).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int CTRL_WIDTH = ALU_CTRL_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [CTRL_WIDTH-1:0] req0_ctrl,
  input  logic [DATA_WIDTH-1:0] req0_op_a,
  input  logic [DATA_WIDTH-1:0] req0_op_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [CTRL_WIDTH-1:0] req1_ctrl,
  input  logic [DATA_WIDTH-1:0] req1_op_a,
  input  logic [DATA_WIDTH-1:0] req1_op_b,
  output logic [CTRL_WIDTH-1:0] alu_ctrl,
  output logic [DATA_WIDTH-1:0] alu_op_a,
  output logic [DATA_WIDTH-1:0] alu_op_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_data
);

  logic elig0_s;
  logic elig1_s;
  logic grant0_s;
  logic grant1_s;
  logic last_grant_r;

  // Nothing is accepted while reset is held, even though the slots are free.
  assign elig0_s = reset_n && req0_valid && (!rsp0_valid || rsp0_ready);
  assign elig1_s = reset_n && req1_valid && (!rsp1_valid || rsp1_ready);

  // Round-robin pick: on a tie, the requester that did not win last time.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (elig0_s && elig1_s) begin
      if (last_grant_r) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else if (elig0_s) begin
      grant0_s = 1'b1;
    end else if (elig1_s) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Remember the last winner; reset value lets requester 0 win the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= 1'b1;
    end else if (grant0_s) begin
      last_grant_r <= 1'b0;
    end else if (grant1_s) begin
      last_grant_r <= 1'b1;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Steer the granted request onto the shared ALU; idle drives zeros.
  always_comb begin
    alu_ctrl = {CTRL_WIDTH{1'b0}};
    alu_op_a = {DATA_WIDTH{1'b0}};
    alu_op_b = {DATA_WIDTH{1'b0}};
    case ({grant1_s, grant0_s})
      2'b01: begin
        alu_ctrl = req0_ctrl;
        alu_op_a = req0_op_a;
        alu_op_b = req0_op_b;
      end
      2'b10: begin
        alu_ctrl = req1_ctrl;
        alu_op_a = req1_op_a;
        alu_op_b = req1_op_b;
      end
      default: begin
        alu_ctrl = {CTRL_WIDTH{1'b0}};
        alu_op_a = {DATA_WIDTH{1'b0}};
        alu_op_b = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_slot0 (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (grant0_s),
    .load_data (alu_result),
    .ready     (rsp0_ready),
    .valid     (rsp0_valid),
    .data      (rsp0_data)
  );

  rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_slot1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (grant1_s),
    .load_data (alu_result),
    .ready     (rsp1_ready),
    .valid     (rsp1_valid),
    .data      (rsp1_data)
  );

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters: requester 0 is the pipeline execute stage, requester 1 is the address/compare helper.
- Each request carries a 6-bit ALU control code and two operands.
- The block grants one request per cycle by round-robin and drives the shared ALU inputs.
- It captures the ALU result into a per-requester one-entry response register with valid/ready handshake.
- It sits between the requesters and the single ALU instance in the execute stage.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- CTRL_WIDTH, 6, ALU control code width.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_ctrl  input  CTRL_WIDTH  requester 0 ALU control code.
- req0_op_a / req0_op_b  input  DATA_WIDTH  requester 0 operands.
- req1_valid, req1_ready, req1_ctrl, req1_op_a, req1_op_b: same as requester 0, for requester 1.
- alu_ctrl  output  CTRL_WIDTH  to shared ALU control input.
- alu_op_a / alu_op_b  output  DATA_WIDTH  to shared ALU operands.
- alu_result  input  DATA_WIDTH  from shared ALU (combinational).
- rsp0_valid  output  1  result pending for requester 0.
- rsp0_ready  input  1  requester 0 consumes result.
- rsp0_data  output  DATA_WIDTH  result for requester 0.
- rsp1_valid, rsp1_ready, rsp1_data: same as requester 0, for requester 1.

Behaviour:
- Reset (reset_n low, asynchronous): rsp0_valid=0, rsp1_valid=0, rsp*_data=0, last_grant=1 (so requester 0 wins the first tie). Any pending responses are discarded. Requests presented during reset are not accepted.
- Eligibility: requester i is eligible when reqi_valid=1 and its slot is free or draining, i.e. (rspi_valid=0 or rspi_ready=1).
- Grant:
  - Only one eligible requester: it is granted.
  - Both eligible: grant goes to the requester not equal to last_grant.
  - None eligible: no grant.
  - last_grant updates only on a grant.
- reqi_ready = granti, combinational from valids, slot state and last_grant. It never depends on alu_result.
- Mux: alu_ctrl/op_a/op_b = the granted requester's fields. With no grant, all are driven 0 and alu_result is ignored.
- Latency: a request accepted at edge N makes rspi_valid=1 with rspi_data=alu_result sampled at edge N. Result is visible the cycle after acceptance; one-cycle latency.
- Response slot:
  - Holds data stable while rspi_valid=1 and rspi_ready=0.
  - Drain (valid&ready) with no new grant: valid clears.
  - Drain plus a new grant in the same cycle: slot reloads and stays valid. Back-to-back throughput is one op per cycle per requester.
- Full slot with rspi_ready=0: requester i is ineligible, and the other requester may take the ALU that cycle (no head-of-line blocking).
- Result is passed through unmodified, including the ALU's zero output for unsupported codes. The arbiter does not decode ctrl.
- Fairness: with both continuously eligible, grants alternate 0,1,0,1,…. Neither waits more than one cycle.
- Request fields must be held stable while reqi_valid=1 and reqi_ready=0. This is a requester obligation, checked by an assertion in the bench.

Decomposition:
- Shared package `alu_pkg` holds the ALU control code constants (ADD, SUB, OR, XOR, AND, SLL, SRL, SRA, SLT, SLTU) and the CTRL_WIDTH/DATA_WIDTH defaults. The arbiter and bench both import it.
- One sub-module is natural: `rsp_slot`, the one-entry valid/ready response register. It is instantiated twice.
- The round-robin pick stays inline.
- The ALU itself is instantiated beside the arbiter at the execute-stage level, not inside it.

Test Plan:
- Single request: req0 ADD op_a=5, op_b=7, rsp0_ready=1 -> req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_data=12; req1 idle, rsp1_valid stays 0.
- Simultaneous contention: both valid for 4 cycles (req0 SUB 10-3, req1 XOR 0xF0^0x0F), both rsp_ready=1 -> grants 0,1,0,1; rsp0_data=7, rsp1_data=0xFF.
- Backpressure: rsp0_ready=0 with a full slot holding 0x1234 while req0 and req1 are valid -> req0_ready=0, req1 granted every cycle; rsp0_data stays 0x1234 until rsp0_ready=1.
- Drain-and-refill: rsp0 full, rsp0_ready=1 and req0 SLT op_a=0xFFFFFFFF, op_b=1 in the same cycle -> rsp0_valid stays 1, data becomes 1 next cycle.
- Reset mid-operation: assert reset_n=0 asynchronously while rsp1_valid=1 -> rsp1_valid=0 immediately without a clock edge; after release, a tie grants requester 0 first.
- Unsupported code: req1_ctrl outside the defined set -> rsp1_data=0, handshake completes normally.
